hazard_ctrl: RTL

//  Pipeline scheduler for the 5-stage MIPS core: decides each cycle whether the F/D

---
 rtl/hazard_ctrl_if.sv | 32 +++
 rtl/hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the pipeline-side signals of the hazard controller.
//   master : pipeline datapath (drives stage instructions, receives controls)
//   slave  : hazard_ctrl       (reads stage instructions, drives controls)
//   Signals:
//     D_Instr, E_Instr, M_Instr  instructions currently held in D, E, M
//     PC_en, D_en                1 = PC / F-D register advance
//     E_clr                      1 = D-E register loads a bubble
//     md_start, md_op, md_busy   mult/div unit sequencing
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
   logic [31:0] D_Instr;
   logic [31:0] E_Instr;
   logic [31:0] M_Instr;
   logic        PC_en;
   logic        D_en;
   logic        E_clr;
   logic        md_start;
   logic [1:0]  md_op;
   logic        md_busy;

   modport master (
      output D_Instr, E_Instr, M_Instr,
      input  PC_en, D_en, E_clr, md_start, md_op, md_busy
   );

   modport slave (
      input  D_Instr, E_Instr, M_Instr,
      output PC_en, D_en, E_clr, md_start, md_op, md_busy
   );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Stall / bubble scheduler for a 5-stage MIPS pipeline.
//   - Register hazards resolved with Tuse (D-stage readers) versus Tnew
//     (producers in E and M).
//   - Sequences the multi-cycle mult/div unit: a start pulse when a
//     mult/multu/div/divu sits in E, then a latency counter while busy.
//     Any HI/LO instruction in D is held while the unit is occupied.
//   Ports:
//     clk    system clock, all state on posedge
//     reset  synchronous active-high reset; forces benign outputs
//     bus    hazard_ctrl_if.slave (stage instructions in, controls out)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic            clk,
   input  logic            reset,
   hazard_ctrl_if.slave    bus
);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   typedef enum logic {IDLE, BUSY} state_t;

   // Source-read profile of an instruction sitting in D.
   typedef struct packed {
      logic       rs_rd;
      logic [1:0] rs_tuse;
      logic       rt_rd;
      logic [1:0] rt_tuse;
      logic       md;
   } src_t;

   // ---------------------------------------------------------------
   // Decode helpers
   // ---------------------------------------------------------------
   function automatic logic is_load(input logic [31:0] ins);
      case (ins[31:26])
         OP_LW, OP_LH, OP_LB, OP_LHU, OP_LBU: is_load = 1'b1;
         default:                             is_load = 1'b0;
      endcase
   endfunction

   // R-type ops that write rd through the ALU (including shifts).
   function automatic logic is_r_alu(input logic [5:0] funct);
      case (funct)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
         6'h26, 6'h27, 6'h2A, 6'h2B:            is_r_alu = 1'b1;
         default:                               is_r_alu = 1'b0;
      endcase
   endfunction

   // mult/multu/div/divu: the ops that launch the unit.
   function automatic logic is_mdop(input logic [31:0] ins);
      is_mdop = (ins[31:26] == OP_SPECIAL) && (ins[5:2] == 4'b0110);
   endfunction

   function automatic logic [4:0] dest_reg(input logic [31:0] ins);
      dest_reg = 5'd0;
      case (ins[31:26])
         OP_SPECIAL: begin
            if (is_r_alu(ins[5:0]) || ins[5:0] == 6'h09 ||
                ins[5:0] == 6'h10 || ins[5:0] == 6'h12)
               dest_reg = ins[15:11];
         end
         OP_ADDIU, OP_ORI, OP_LUI,
         OP_LW, OP_LH, OP_LB, OP_LHU, OP_LBU: dest_reg = ins[20:16];
         OP_JAL:                              dest_reg = 5'd31;
         default:                             dest_reg = 5'd0;
      endcase
   endfunction

   // Only meaningful when dest_reg is nonzero; jal/jalr link values are
   // ready as soon as they reach E.
   function automatic logic [1:0] tnew_e(input logic [31:0] ins);
      if (is_load(ins))
         tnew_e = 2'd2;
      else if (ins[31:26] == OP_JAL ||
               (ins[31:26] == OP_SPECIAL && ins[5:0] == 6'h09))
         tnew_e = 2'd0;
      else
         tnew_e = 2'd1;
   endfunction

   function automatic src_t src_info(input logic [31:0] ins);
      src_t s;
      s = '0;
      case (ins[31:26])
         OP_SPECIAL: begin
            case (ins[5:0])
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07,
               6'h18, 6'h19, 6'h1A, 6'h1B: begin
                  s.rs_rd = 1'b1; s.rs_tuse = 2'd1;
                  s.rt_rd = 1'b1; s.rt_tuse = 2'd1;
               end
               6'h00, 6'h02, 6'h03: begin
                  s.rt_rd = 1'b1; s.rt_tuse = 2'd1;
               end
               6'h08, 6'h09: begin
                  s.rs_rd = 1'b1; s.rs_tuse = 2'd0;
               end
               6'h11, 6'h13: begin
                  s.rs_rd = 1'b1; s.rs_tuse = 2'd1;
               end
               default: ;
            endcase
            s.md = (ins[5:2] == 4'b0100) || (ins[5:2] == 4'b0110);
         end
         OP_BEQ, OP_BNE: begin
            s.rs_rd = 1'b1; s.rs_tuse = 2'd0;
            s.rt_rd = 1'b1; s.rt_tuse = 2'd0;
         end
         OP_ADDIU, OP_ORI,
         OP_LW, OP_LH, OP_LB, OP_LHU, OP_LBU: begin
            s.rs_rd = 1'b1; s.rs_tuse = 2'd1;
         end
         OP_SW, OP_SH, OP_SB: begin
            s.rs_rd = 1'b1; s.rs_tuse = 2'd1;
            s.rt_rd = 1'b1; s.rt_tuse = 2'd2;
         end
         default: ;
      endcase
      return s;
   endfunction

   function automatic logic hit(input logic [4:0] src, input logic rd_en,
                                input logic [1:0] tuse, input logic [4:0] dst,
                                input logic [1:0] tnew);
      hit = rd_en && (dst != 5'd0) && (src == dst) && (tuse < tnew);
   endfunction

   // ---------------------------------------------------------------
   // Register hazard detection
   // ---------------------------------------------------------------
   src_t       d_src;
   logic [4:0] d_rs, d_rt;
   logic [4:0] e_dst, m_dst;
   logic [1:0] e_tnew, m_tnew;
   logic       hz_stall;

   assign d_src  = src_info(bus.D_Instr);
   assign d_rs   = bus.D_Instr[25:21];
   assign d_rt   = bus.D_Instr[20:16];
   assign e_dst  = dest_reg(bus.E_Instr);
   assign m_dst  = dest_reg(bus.M_Instr);
   assign e_tnew = tnew_e(bus.E_Instr);
   assign m_tnew = is_load(bus.M_Instr) ? 2'd1 : 2'd0;

   assign hz_stall = hit(d_rs, d_src.rs_rd, d_src.rs_tuse, e_dst, e_tnew) ||
                     hit(d_rt, d_src.rt_rd, d_src.rt_tuse, e_dst, e_tnew) ||
                     hit(d_rs, d_src.rs_rd, d_src.rs_tuse, m_dst, m_tnew) ||
                     hit(d_rt, d_src.rt_rd, d_src.rt_tuse, m_dst, m_tnew);

   // ---------------------------------------------------------------
   // Mult/div sequencing FSM
   // ---------------------------------------------------------------
   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               start_raw;
   logic               busy_raw;
   logic               md_stall;
   logic               stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      start_raw  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (is_mdop(bus.E_Instr)) begin
               start_raw  = 1'b1;
               state_next = BUSY;
               // funct bit 1 separates div/divu from mult/multu
               cnt_next   = bus.E_Instr[1] ? CNT_W'(DIV_CYCLES)
                                           : CNT_W'(MULT_CYCLES);
            end
         end
         BUSY: begin
            if (cnt_reg == CNT_W'(1)) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt_reg - CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign busy_raw = start_raw || (state_reg == BUSY);
   assign md_stall = d_src.md && busy_raw;
   assign stall    = hz_stall || md_stall;

   // While reset is held every control is forced to its free-running value.
   always_comb begin
      bus.PC_en    = 1'b1;
      bus.D_en     = 1'b1;
      bus.E_clr    = 1'b0;
      bus.md_start = 1'b0;
      bus.md_op    = 2'b00;
      bus.md_busy  = 1'b0;
      if (!reset) begin
         bus.PC_en    = !stall;
         bus.D_en     = !stall;
         bus.E_clr    = stall;
         bus.md_start = start_raw;
         bus.md_op    = start_raw ? bus.E_Instr[1:0] : 2'b00;
         bus.md_busy  = busy_raw;
      end
   end

endmodule
